// File: rtl/fp_recip_arbiter.sv
// Round-robin front end for one shared combinational FP32 reciprocal unit.
// The result is held in a one-entry response register tagged with the owning requester.
module fp_recip_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ*32-1:0]  req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic [31:0]          recip_in,
  input  logic [31:0]          recip_out,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_data,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 rsp_special,
  input  logic                 rsp_ready,
  output logic [CNT_W-1:0]     op_count
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // a requester keeps valid and data stable until it sees ready.
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state, state_next;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant;
  logic [ID_W:0]   idx;
  logic            found;
  logic            can_accept;
  logic            accept;
  logic            special;
  logic [31:0]     lane [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_lane
    assign lane[g] = req_data[32*g +: 32];
  end

  // Search from rr_ptr upward; the sum never exceeds 2*N_REQ-2, so one wrap suffices.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(N_REQ)) idx = idx - (ID_W+1)'(N_REQ);
      if (!found && req_valid[idx[ID_W-1:0]]) begin
        found = 1'b1;
        grant = idx[ID_W-1:0];
      end
    end
  end

  assign rsp_valid  = (state == FULL);
  assign can_accept = !rsp_valid || rsp_ready;
  assign accept     = can_accept && found;
  assign recip_in   = found ? lane[grant] : 32'h0;
  assign req_ready  = accept ? (N_REQ'(1) << grant) : '0;
  assign special    = (recip_in[30:23] == 8'hFF) || (recip_in[30:0] == 31'h0);

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (accept) state_next = FULL;
      FULL: begin
        if (accept)         state_next = FULL;
        else if (rsp_ready) state_next = EMPTY;
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  // Response fields only move on accept, so a drain leaves the last result visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data    <= 32'h0;
      rsp_id      <= '0;
      rsp_special <= 1'b0;
      rr_ptr      <= '0;
      op_count    <= '0;
    end else if (accept) begin
      rsp_data    <= recip_out;
      rsp_id      <= grant;
      rsp_special <= special;
      rr_ptr      <= (grant == ID_W'(N_REQ-1)) ? '0 : grant + 1'b1;
      op_count    <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_recip_arbiter.sv
// Bench for fp_recip_arbiter: vector table, directed multi-cycle sequences, random traffic,
// with a reference arbitration model feeding an expected-response queue.
module tb_fp_recip_arbiter;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;
  localparam int CNT_W = 4;
  localparam int EXP_W = ID_W + 1 + 32;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [N_REQ-1:0]    req_valid = '0;
  logic [N_REQ*32-1:0] req_data = '0;
  logic [N_REQ-1:0]    req_ready;
  logic [31:0]         recip_in;
  logic [31:0]         recip_out;
  logic                rsp_valid;
  logic [31:0]         rsp_data;
  logic [ID_W-1:0]     rsp_id;
  logic                rsp_special;
  logic                rsp_ready = 1'b1;
  logic [CNT_W-1:0]    op_count;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [EXP_W-1:0] exp_q[$];
  logic [31:0]      src_q [N_REQ][$];
  logic [N_REQ-1:0] fired = '0;
  int               seen_id[$];
  int               seen_cyc[$];

  // Reference model state
  logic             m_full = 1'b0;
  int               m_ptr = 0;
  logic [CNT_W-1:0] m_cnt = '0;
  int               e_grant;
  logic             e_found;
  logic             e_can;
  logic [N_REQ-1:0] e_ready;
  logic [31:0]      e_opnd;
  logic [EXP_W-1:0] e_item;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     opnd;
    logic [31:0]     res;
    logic            spec;
  } vec_t;
  vec_t vecs [8];

  fp_recip_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .recip_in(recip_in), .recip_out(recip_out),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_special(rsp_special), .rsp_ready(rsp_ready), .op_count(op_count)
  );

  // Stand-in for the shared reciprocal unit: exact for specials and powers of two.
  function automatic logic [31:0] recip_model(input logic [31:0] a);
    logic [7:0] e;
    e = a[30:23];
    if (e == 8'hFF) return (a[22:0] != 23'h0) ? (a | 32'h0040_0000) : {a[31], 31'h0};
    if (a[30:0] == 31'h0) return {a[31], 8'hFF, 23'h0};
    if (a[22:0] == 23'h0 && e <= 8'd253) return {a[31], 8'd254 - e, 23'h0};
    return {a[31], 8'd253 - e, ~a[22:0]};
  endfunction

  assign recip_out = recip_model(recip_in);

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor + model: checks combinational outputs, scores responses, predicts accepts.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_full = 1'b0;
      m_ptr  = 0;
      m_cnt  = '0;
      fired  = '0;
      exp_q.delete();
    end else begin
      cyc++;
      e_found = 1'b0;
      e_grant = 0;
      for (int k = 0; k < N_REQ; k++) begin
        if (!e_found && req_valid[(m_ptr + k) % N_REQ]) begin
          e_found = 1'b1;
          e_grant = (m_ptr + k) % N_REQ;
        end
      end
      e_can   = !m_full || rsp_ready;
      e_ready = '0;
      if (e_found && e_can) e_ready[e_grant] = 1'b1;
      e_opnd  = e_found ? req_data[32*e_grant +: 32] : 32'h0;
      check("req_ready", req_ready, e_ready);
      check("recip_in", recip_in, e_opnd);
      check("rsp_valid", rsp_valid, m_full);
      check("op_count", op_count, m_cnt);
      if (m_full && rsp_ready) begin
        check("exp_q_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e_item = exp_q.pop_front();
          check("rsp_id", rsp_id, e_item[EXP_W-1 -: ID_W]);
          check("rsp_special", rsp_special, e_item[32]);
          check("rsp_data", rsp_data, e_item[31:0]);
        end
        seen_id.push_back(int'(rsp_id));
        seen_cyc.push_back(cyc);
      end
      fired = req_valid & req_ready;
      if (e_found && e_can) begin
        exp_q.push_back({ID_W'(e_grant),
                         (e_opnd[30:23] == 8'hFF) || (e_opnd[30:0] == 31'h0),
                         recip_model(e_opnd)});
        m_ptr  = (e_grant + 1) % N_REQ;
        m_cnt  = m_cnt + 1'b1;
        m_full = 1'b1;
      end else if (m_full && rsp_ready) begin
        m_full = 1'b0;
      end
    end
  end

  // Requester drivers: hold each operand until it is seen accepted, then load the next.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      req_valid = '0;
      for (int i = 0; i < N_REQ; i++) src_q[i].delete();
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (fired[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && src_q[i].size() > 0) begin
          req_data[32*i +: 32] = src_q[i].pop_front();
          req_valid[i] = 1'b1;
        end
      end
    end
  end

  task automatic send(input int id, input logic [31:0] d);
    src_q[id].push_back(d);
  endtask

  task automatic drive_ready(input logic v);
    @(posedge clk);
    #2;
    rsp_ready = v;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic wait_seen(input int n, input string name);
    for (int t = 0; t < 100 && seen_id.size() < n; t++) begin
      @(negedge clk);
      #1;
    end
    check(name, seen_id.size(), n);
  endtask

  task automatic wait_full(input string name);
    for (int t = 0; t < 50 && rsp_valid !== 1'b1; t++) begin
      @(negedge clk);
      #1;
    end
    check(name, rsp_valid, 1);
  endtask

  function automatic logic [31:0] rand_opnd();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0:       return {r[31], 31'h0};
      1:       return {r[31], 8'hFF, 1'b1, r[21:0]};
      2:       return {r[31], 8'hFF, 23'h0};
      3:       return {r[31], 8'($urandom_range(1, 253)), r[22:0]};
      default: return {r[31], 8'($urandom_range(1, 253)), 23'h0};
    endcase
  endfunction

  initial begin
    vecs[0] = '{2'd0, 32'h4000_0000, 32'h3F00_0000, 1'b0};
    vecs[1] = '{2'd1, 32'h8000_0000, 32'hFF80_0000, 1'b1};
    vecs[2] = '{2'd1, 32'h7FC0_0000, 32'h7FC0_0000, 1'b1};
    vecs[3] = '{2'd2, 32'h0000_0000, 32'h7F80_0000, 1'b1};
    vecs[4] = '{2'd3, 32'h7F80_0000, 32'h0000_0000, 1'b1};
    vecs[5] = '{2'd2, 32'h3F80_0000, 32'h3F80_0000, 1'b0};
    vecs[6] = '{2'd3, 32'hC080_0000, 32'hBE80_0000, 1'b0};
    vecs[7] = '{2'd0, 32'hFF80_0000, 32'h8000_0000, 1'b1};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_rsp_id", rsp_id, 0);
    check("reset_rsp_special", rsp_special, 0);
    check("reset_op_count", op_count, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Single-operation vectors
    for (int v = 0; v < 8; v++) begin
      seen_id.delete();
      seen_cyc.delete();
      send(int'(vecs[v].id), vecs[v].opnd);
      wait_seen(1, "vec_timeout");
      check("vec_valid", rsp_valid, 1);
      check("vec_id", rsp_id, vecs[v].id);
      check("vec_data", rsp_data, vecs[v].res);
      check("vec_special", rsp_special, vecs[v].spec);
      if (v == 0) check("vec_first_count", op_count, 1);
    end
    @(negedge clk);
    #1;
    check("vec_final_count", op_count, 8);

    // Round robin with all requesters pending, back to back
    do_reset();
    seen_id.delete();
    seen_cyc.delete();
    send(0, 32'h3F80_0000);
    send(1, 32'h4000_0000);
    send(2, 32'h4080_0000);
    send(3, 32'h4100_0000);
    send(0, 32'h4180_0000);
    wait_seen(5, "rr_timeout");
    for (int i = 0; i < 5; i++) check("rr_id", seen_id[i], (i == 4) ? 0 : i);
    for (int i = 1; i < 5; i++) check("rr_no_bubble", seen_cyc[i] - seen_cyc[i-1], 1);

    // Backpressure: five stalled cycles, then release in rr order
    drive_ready(1'b0);
    send(2, 32'h4100_0000);
    wait_full("bp_fill");
    send(3, 32'h3F80_0000);
    send(1, 32'hC000_0000);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      check("bp_valid", rsp_valid, 1);
      check("bp_id", rsp_id, 2);
      check("bp_data", rsp_data, 32'h3E00_0000);
      check("bp_req_ready", req_ready, 0);
      check("bp_count", op_count, 6);
    end
    seen_id.delete();
    seen_cyc.delete();
    drive_ready(1'b1);
    wait_seen(3, "bp_timeout");
    check("bp_order0", seen_id[0], 2);
    check("bp_order1", seen_id[1], 3);
    check("bp_order2", seen_id[2], 1);

    // Drain and accept in the same cycle
    drive_ready(1'b0);
    send(0, 32'h4000_0000);
    wait_full("da_fill");
    send(2, 32'h3F80_0000);
    repeat (3) @(negedge clk);
    seen_id.delete();
    seen_cyc.delete();
    drive_ready(1'b1);
    wait_seen(2, "da_timeout");
    check("da_id0", seen_id[0], 0);
    check("da_id1", seen_id[1], 2);
    check("da_no_bubble", seen_cyc[1] - seen_cyc[0], 1);

    // Asynchronous reset while FULL and stalled
    drive_ready(1'b0);
    send(3, 32'h4000_0000);
    wait_full("ar_fill");
    send(2, 32'h4080_0000);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_rsp_valid", rsp_valid, 0);
    check("ar_op_count", op_count, 0);
    check("ar_rsp_id", rsp_id, 0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    seen_id.delete();
    seen_cyc.delete();
    send(1, 32'h3F80_0000);
    send(0, 32'h4000_0000);
    drive_ready(1'b1);
    wait_seen(2, "ar_timeout");
    check("ar_first", seen_id[0], 0);
    check("ar_second", seen_id[1], 1);

    // Random traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #2;
      rsp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        automatic int id = $urandom_range(0, N_REQ-1);
        if (src_q[id].size() < 3) send(id, rand_opnd());
      end
    end
    @(posedge clk);
    #2;
    rsp_ready = 1'b1;
    for (int t = 0; t < 200 && (req_valid != '0 || rsp_valid || exp_q.size() > 0); t++) begin
      @(negedge clk);
      #1;
    end
    check("drain_exp_q", exp_q.size(), 0);
    check("drain_req_valid", req_valid, 0);
    check("drain_rsp_valid", rsp_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
